// File: rtl/addsub_seq_chunked_if.sv
// Operand request / result handshake bundle for the chunked adder/subtractor.
// The master side drives operands and accepts results; the slave is the arithmetic unit.
interface addsub_seq_chunked_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;
    logic             zero;
    logic [WIDTH-1:0] acc;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, cout, ovf, zero, acc
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, cout, ovf, zero, acc
    );
endinterface

// File: rtl/addsub_seq_chunked.sv
// Multi-cycle adder/subtractor: CHUNK bits per cycle with a registered ripple carry,
// an accumulator operand mode, carry/overflow/zero flags and valid/ready on both sides.
module addsub_seq_chunked #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CHUNK = 4
) (
    input logic                 clk,
    input logic                 rst,
    addsub_seq_chunked_if.slave bus
);
    localparam int unsigned N    = WIDTH / CHUNK;
    localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic             carry_q, carry_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             sign_a_q, sign_a_d;
    logic             sign_b_q, sign_b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] acc_q, acc_d;

    logic [CHUNK-1:0] chunk_a;
    logic [CHUNK-1:0] chunk_b;
    logic [CHUNK:0]   chunk_sum;
    logic [WIDTH-1:0] r_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            op_a_q   <= '0;
            op_b_q   <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            r_q      <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            acc_q    <= '0;
        end else begin
            state_q  <= state_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            r_q      <= r_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
            acc_q    <= acc_d;
        end
    end

    // One chunk of the ripple add; r_full is the working result with this chunk merged in.
    always_comb begin
        chunk_a   = op_a_q[cnt_q * CHUNK +: CHUNK];
        chunk_b   = op_b_q[cnt_q * CHUNK +: CHUNK];
        chunk_sum = {1'b0, chunk_a} + {1'b0, chunk_b} + {{CHUNK{1'b0}}, carry_q};
        r_full    = r_q;
        r_full[cnt_q * CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
    end

    always_comb begin
        state_d  = state_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        r_d      = r_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        acc_d    = acc_q;

        case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    op_a_d   = bus.op[1] ? acc_q : bus.a;
                    op_b_d   = bus.op[0] ? ~bus.b : bus.b;
                    // Subtraction is A + ~B + 1, so the initial carry is the op LSB.
                    carry_d  = bus.op[0];
                    sign_a_d = op_a_d[WIDTH-1];
                    sign_b_d = op_b_d[WIDTH-1];
                    cnt_d    = '0;
                    r_d      = '0;
                    state_d  = StCalc;
                end
            end
            StCalc: begin
                r_d     = r_full;
                carry_d = chunk_sum[CHUNK];
                if (cnt_q == LastCnt) begin
                    result_d = r_full;
                    cout_d   = chunk_sum[CHUNK];
                    ovf_d    = (sign_a_q == sign_b_q) && (r_full[WIDTH-1] != sign_a_q);
                    zero_d   = (r_full == '0);
                    acc_d    = r_full;
                    state_d  = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.result    = result_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
    assign bus.acc       = acc_q;
endmodule
